// File: rtl/reg_bank_pkg.sv
// Shared helpers for software-visible register blocks.
package reg_bank_pkg;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_fifo_mem.sv
// Entry storage for the write-only FIFO register.
// It has a synchronous write port and an asynchronous read of the head entry. It is never reset.
module reg_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wo_fifo_reg.sv
// Software write-only register backed by a small FIFO and drained by hardware over VALID/READY.
// This module holds the pointers, the occupancy counter and the status flags. Storage lives in reg_fifo_mem.
module wo_fifo_reg
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        WEN,
  input  logic [DATA_WIDTH-1:0]       VALUE_IN,
  output logic                        HW_VALID,
  output logic [DATA_WIDTH-1:0]       HW_DATA,
  input  logic                        HW_READY,
  output logic                        FULL,
  output logic                        EMPTY,
  output logic [lvl_w(DEPTH)-1:0]     LEVEL,
  output logic                        OVERFLOW,
  input  logic                        OVF_CLR
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wo_fifo_reg: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A full FIFO refuses the write even when a pop happens in the same cycle, so there is no bypass path.
  always_comb begin
    push     = WEN && !full;
    pop      = !empty && HW_READY;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // When a write is dropped in the same cycle as a clear, the set takes priority.
    if (WEN && full) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  reg_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (VALUE_IN),
    .raddr (rd_ptr_q),
    .rdata (HW_DATA)
  );

  assign HW_VALID = !empty;
  assign FULL     = full;
  assign EMPTY    = empty;
  assign LEVEL    = level_q;
  assign OVERFLOW = ovf_q;

endmodule
